// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: request, response and ALU operand bus of the
// ALU issue controller. slave = controller side, master = requester/ALU side.
interface alu_issue_ctrl_if #(
   parameter int WIDTH = 64
);
   logic             req_valid;
   logic             req_ready;
   logic [2:0]       req_op;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;

   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [2:0]       alu_sel;
   logic [WIDTH-1:0] alu_result;
   logic             alu_ovf;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_zero;
   logic             rsp_ovf;
   logic             rsp_err;

   modport slave (
      input  req_valid, req_op, req_a, req_b,
      input  alu_result, alu_ovf,
      input  rsp_ready,
      output req_ready,
      output alu_a, alu_b, alu_sel,
      output rsp_valid, rsp_result, rsp_zero, rsp_ovf, rsp_err
   );

   modport master (
      output req_valid, req_op, req_a, req_b,
      output alu_result, alu_ovf,
      output rsp_ready,
      input  req_ready,
      input  alu_a, alu_b, alu_sel,
      input  rsp_valid, rsp_result, rsp_zero, rsp_ovf, rsp_err
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: holds operands on the ALU for an op-dependent time,
// captures the result and returns it. Optional macro: ALU_STICKY_OVF_EN.
module alu_issue_ctrl #(
   parameter int WIDTH     = 64,
   parameter int BASIC_LAT = 1,
   parameter int MUL_LAT   = 4,
   parameter int DIV_LAT   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_issue_ctrl_if.slave  bus,
`ifdef ALU_STICKY_OVF_EN
   input  logic             sticky_clr,
   output logic             sticky_ovf,
`endif
   output logic             busy
);

   localparam int MAXL_BM = (BASIC_LAT > MUL_LAT) ? BASIC_LAT : MUL_LAT;
   localparam int MAXL    = (MAXL_BM > DIV_LAT) ? MAXL_BM : DIV_LAT;
   localparam int CW      = (MAXL > 1) ? $clog2(MAXL) : 1;

   localparam logic [CW-1:0] L_BASIC = CW'(BASIC_LAT - 1);
   localparam logic [CW-1:0] L_MUL   = CW'(MUL_LAT - 1);
   localparam logic [CW-1:0] L_DIV   = CW'(DIV_LAT - 1);

   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_RESP
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   logic [2:0]       r_alu_sel;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_ovf;
   logic             r_err;

   logic             w_accept;
   logic             w_illegal;
   logic             w_divz;
   logic             w_done;
   logic             w_logic_op;
   logic             w_cap_ovf;
   logic [CW-1:0]    w_lat;

   assign w_accept   = (r_state == S_IDLE) & bus.req_valid;
   assign w_illegal  = bus.req_op[2] & bus.req_op[1];
   assign w_divz     = (bus.req_op == OP_DIV) & (bus.req_b == '0);
   assign w_done     = (r_state == S_EXEC) & (r_cnt == '0);
   assign w_logic_op = (r_alu_sel == OP_AND) | (r_alu_sel == OP_OR);
   assign w_cap_ovf  = bus.alu_ovf & ~w_logic_op;

   // Hold count for the incoming op, loaded on accept.
   always_comb begin
      w_lat = L_BASIC;
      unique case (bus.req_op)
         OP_MUL:  w_lat = L_MUL;
         OP_DIV:  w_lat = L_DIV;
         default: w_lat = L_BASIC;
      endcase
   end

   // Next-state logic; error ops skip EXEC entirely.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (bus.req_valid) begin
               if (w_illegal | w_divz)
                  w_next = S_RESP;
               else
                  w_next = S_EXEC;
            end
         end
         S_EXEC: begin
            if (r_cnt == '0)
               w_next = S_RESP;
         end
         S_RESP: begin
            if (bus.rsp_ready)
               w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // Operand latch, hold counter and response capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_alu_a   <= '0;
         r_alu_b   <= '0;
         r_alu_sel <= '0;
         r_result  <= '0;
         r_zero    <= 1'b0;
         r_ovf     <= 1'b0;
         r_err     <= 1'b0;
      end else if (w_accept) begin
         r_alu_a   <= bus.req_a;
         r_alu_b   <= bus.req_b;
         r_alu_sel <= bus.req_op;
         r_cnt     <= w_lat;
         if (w_illegal) begin
            r_result <= '0;
            r_zero   <= 1'b1;
            r_ovf    <= 1'b0;
            r_err    <= 1'b1;
         end else if (w_divz) begin
            r_result <= '1;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b1;
            r_err    <= 1'b1;
         end
      end else if (r_state == S_EXEC) begin
         if (r_cnt == '0) begin
            r_result <= bus.alu_result;
            r_zero   <= ~|bus.alu_result;
            r_ovf    <= w_cap_ovf;
            r_err    <= 1'b0;
         end else begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

`ifdef ALU_STICKY_OVF_EN
   logic w_sticky_set;
   logic r_sticky;

   assign w_sticky_set = (w_accept & (w_illegal | w_divz))
                       | (w_done & w_cap_ovf);

   // Sticky flag: set beats clear on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_sticky <= 1'b0;
      else if (w_sticky_set)
         r_sticky <= 1'b1;
      else if (sticky_clr)
         r_sticky <= 1'b0;
   end

   assign sticky_ovf = r_sticky;
`endif

   assign bus.req_ready  = (r_state == S_IDLE);
   assign bus.rsp_valid  = (r_state == S_RESP);
   assign bus.alu_a      = r_alu_a;
   assign bus.alu_b      = r_alu_b;
   assign bus.alu_sel    = r_alu_sel;
   assign bus.rsp_result = r_result;
   assign bus.rsp_zero   = r_zero;
   assign bus.rsp_ovf    = r_ovf;
   assign bus.rsp_err    = r_err;
   assign busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed vectors for alu_issue_ctrl with a
// behavioural ALU; latency counted in edges from accept to rsp handshake.
module tb_alu_issue_ctrl;

   logic clk;
   logic rst_n;
   logic busy;
   logic tb_ovf;
   logic sticky_clr;
   logic sticky_ovf;
   int   n_tests;
   int   n_fail;
   int   lat;
   int   hold;
   logic seen;

   alu_issue_ctrl_if #(.WIDTH(64)) bus ();

   alu_issue_ctrl #(
      .WIDTH(64), .BASIC_LAT(1), .MUL_LAT(4), .DIV_LAT(8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
`ifdef ALU_STICKY_OVF_EN
      .sticky_clr (sticky_clr),
      .sticky_ovf (sticky_ovf),
`endif
      .busy       (busy)
   );

`ifndef ALU_STICKY_OVF_EN
   assign sticky_ovf = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU.
   always_comb begin
      bus.alu_result = '0;
      case (bus.alu_sel)
         3'd0: bus.alu_result = bus.alu_a + bus.alu_b;
         3'd1: bus.alu_result = bus.alu_a - bus.alu_b;
         3'd2: bus.alu_result = bus.alu_a * bus.alu_b;
         3'd3: bus.alu_result = (bus.alu_b != 0) ?
                                bus.alu_a / bus.alu_b : '1;
         3'd4: bus.alu_result = bus.alu_a & bus.alu_b;
         3'd5: bus.alu_result = bus.alu_a | bus.alu_b;
         default: bus.alu_result = '0;
      endcase
      bus.alu_ovf = tb_ovf;
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one request, return edges until handshake and hold count.
   task automatic issue(input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, output int l,
                        output int h);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      l = 0;
      h = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         l++;
         if (bus.rsp_valid) break;
         if (bus.alu_a === a && bus.alu_b === b && bus.alu_sel === op)
            h++;
      end
      if (!bus.rsp_valid) chk("rsp_timeout", 64'd0, 64'd1);
   endtask

   task automatic take_rsp();
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
   endtask

   initial begin
      n_tests       = 0;
      n_fail        = 0;
      tb_ovf        = 1'b0;
      sticky_clr    = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_op    = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b0;
      rst_n         = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_result", bus.rsp_result, 64'd0);
      chk("rst_alu_a", bus.alu_a, 64'd0);
      chk("rst_alu_sel", 64'(bus.alu_sel), 64'd0);
      chk("rst_flags", {61'd0, bus.rsp_zero, bus.rsp_ovf, bus.rsp_err},
          64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_sticky", 64'(sticky_ovf), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // add 5+7
      issue(3'b000, 64'd5, 64'd7, lat, hold);
      chk("add_lat", 64'(lat), 64'd2);
      chk("add_res", bus.rsp_result, 64'd12);
      chk("add_flags", {61'd0, bus.rsp_zero, bus.rsp_ovf, bus.rsp_err},
          64'd0);
      take_rsp();
      chk("add_idle", 64'(bus.req_ready), 64'd1);

      // sub to zero, response held off for 3 cycles
      issue(3'b001, 64'd9, 64'd9, lat, hold);
      chk("sub_res", bus.rsp_result, 64'd0);
      chk("sub_zero", 64'(bus.rsp_zero), 64'd1);
      chk("sub_err", 64'(bus.rsp_err), 64'd0);
      seen = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (!(bus.rsp_valid === 1'b1 && bus.req_ready === 1'b0 &&
               bus.rsp_result === 64'd0 && bus.rsp_zero === 1'b1))
            seen = 1'b0;
      end
      chk("sub_stall", 64'(seen), 64'd1);
      take_rsp();

      // mul 6*7
      issue(3'b010, 64'd6, 64'd7, lat, hold);
      chk("mul_lat", 64'(lat), 64'd5);
      chk("mul_hold", 64'(hold), 64'd4);
      chk("mul_res", bus.rsp_result, 64'd42);
      take_rsp();

      // div by zero
      issue(3'b011, 64'd100, 64'd0, lat, hold);
      chk("dz_lat", 64'(lat), 64'd1);
      chk("dz_res", bus.rsp_result, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("dz_flags", {61'd0, bus.rsp_zero, bus.rsp_ovf, bus.rsp_err},
          64'd3);
      take_rsp();

      // illegal op
      issue(3'b111, 64'd3, 64'd4, lat, hold);
      chk("ill_lat", 64'(lat), 64'd1);
      chk("ill_res", bus.rsp_result, 64'd0);
      chk("ill_flags", {61'd0, bus.rsp_zero, bus.rsp_ovf, bus.rsp_err},
          64'd5);
      take_rsp();

      // and with ALU overflow high: overflow masked
      tb_ovf = 1'b1;
      issue(3'b100, 64'hF0F0, 64'h0FF0, lat, hold);
      chk("and_res", bus.rsp_result, 64'h00F0);
      chk("and_ovf", 64'(bus.rsp_ovf), 64'd0);
      take_rsp();
      tb_ovf = 1'b0;

      // divide 100/4
      issue(3'b011, 64'd100, 64'd4, lat, hold);
      chk("div_lat", 64'(lat), 64'd9);
      chk("div_res", bus.rsp_result, 64'd25);
      take_rsp();

      // reset during div, third EXEC cycle
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = 3'b011;
      bus.req_a     = 64'd100;
      bus.req_b     = 64'd5;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mrst_busy", 64'(busy), 64'd0);
      chk("mrst_ready", 64'(bus.req_ready), 64'd1);
      chk("mrst_alu", {bus.alu_a[59:0], 1'b0, bus.alu_sel}, 64'd0);
      chk("mrst_rsp", {bus.rsp_result[62:0], bus.rsp_valid}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.rsp_valid !== 1'b0) seen = 1'b1;
      end
      chk("mrst_no_rsp", 64'(seen), 64'd0);
      issue(3'b000, 64'd1, 64'd1, lat, hold);
      chk("mrst_add", bus.rsp_result, 64'd2);
      take_rsp();

`ifdef ALU_STICKY_OVF_EN
      tb_ovf = 1'b1;
      issue(3'b000, 64'd1, 64'd2, lat, hold);
      tb_ovf = 1'b0;
      chk("st_ovf", 64'(bus.rsp_ovf), 64'd1);
      chk("st_set", 64'(sticky_ovf), 64'd1);
      take_rsp();
      issue(3'b000, 64'd1, 64'd2, lat, hold);
      take_rsp();
      chk("st_persist", 64'(sticky_ovf), 64'd1);
      @(negedge clk);
      sticky_clr = 1'b1;
      @(posedge clk);
      #1;
      sticky_clr = 1'b0;
      chk("st_clr", 64'(sticky_ovf), 64'd0);
      @(negedge clk);
      sticky_clr    = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_op    = 3'b011;
      bus.req_a     = 64'd7;
      bus.req_b     = 64'd0;
      @(posedge clk);
      #1;
      sticky_clr    = 1'b0;
      bus.req_valid = 1'b0;
      chk("st_set_wins", 64'(sticky_ovf), 64'd1);
      take_rsp();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequential initiator for the 64-bit combinational ALU datapath (add, sub, mul, div, and, or).
- Accepts operation requests over a valid/ready handshake and holds the operands and select stable on the ALU inputs for an op-dependent number of cycles.
- Captures the result and overflow flag, computes zero locally, and returns them over a valid/ready response channel.
- Sits between the processor control path and the ALU, so that multi-cycle multiply/divide paths can be timed safely.

Parameters:
- WIDTH, 64, datapath width of operands and result.
- BASIC_LAT, 1, cycles to hold inputs for add/sub/and/or before capture (min 1).
- MUL_LAT, 4, cycles to hold inputs for multiply before capture (min 1).
- DIV_LAT, 8, cycles to hold inputs for divide before capture (min 1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_op  in  3  000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or; 110/111 illegal.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- alu_a  out  WIDTH  operand A driven to the ALU.
- alu_b  out  WIDTH  operand B driven to the ALU.
- alu_sel  out  3  op select driven to the ALU.
- alu_result  in  WIDTH  ALU result.
- alu_ovf  in  1  ALU overflow flag.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  WIDTH  captured result.
- rsp_zero  out  1  1 when rsp_result == 0.
- rsp_ovf  out  1  captured overflow.
- rsp_err  out  1  illegal op, or divide by zero.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE, counter = 0.
  - alu_a, alu_b, rsp_result = 0; alu_sel = 000.
  - rsp_valid, rsp_zero, rsp_ovf, rsp_err = 0; req_ready = 1.
  - An operation in flight is discarded; no response is produced.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, register req_a/req_b/req_op into alu_a/alu_b/alu_sel.
  - Legal op: load counter with the op's latency minus 1, go to EXEC.
  - Illegal op (110/111): go directly to RESP with rsp_result = 0, rsp_zero = 1, rsp_ovf = 0, rsp_err = 1. The ALU inputs are still registered but ignored.
  - Divide with req_b == 0: go directly to RESP with rsp_result = all ones, rsp_zero = 0, rsp_ovf = 1, rsp_err = 1.
- EXEC:
  - req_ready = 0; alu_a/alu_b/alu_sel held constant.
  - Counter decrements each cycle.
  - On the cycle counter == 0: capture alu_result and alu_ovf into rsp_result and rsp_ovf; rsp_zero = ~|alu_result; rsp_err = 0; go to RESP.
  - Latency from the accept edge to rsp_valid high = op latency + 1 cycles (add with BASIC_LAT=1: rsp_valid is high 2 cycles after accept).
  - For and/or, rsp_ovf is forced to 0 regardless of alu_ovf.
- RESP:
  - rsp_valid = 1; response fields stable until the handshake.
  - On rsp_ready, go to IDLE and drop rsp_valid next cycle. rsp_result and the flags keep their last value.
  - req_ready = 0 in RESP: no overlap, at most one op in flight. Back-to-back ops therefore take one IDLE cycle between them.
- Simultaneous events:
  - req_valid held while not ready: no effect; the requester must hold its payload.
  - rsp_ready asserted outside RESP: ignored.
- Zero is computed from the captured result, never from a combinational ALU flag.

Optional Feature:
- Macro: ALU_STICKY_OVF_EN.
- When defined:
  - Adds input sticky_clr (1) and output sticky_ovf (1), reset 0.
  - sticky_ovf is set on any RESP-entry cycle with rsp_ovf = 1 or rsp_err = 1.
  - sticky_ovf is cleared by sticky_clr=1 at the clock edge. If set and clear occur in the same cycle, set wins.
- When undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
- Add: op=000, a=5, b=7 -> rsp_valid 2 cycles after accept, result=12, zero=0, ovf=alu_ovf=0, err=0.
- Sub to zero: op=001, a=9, b=9 -> result=0, zero=1, err=0. Hold rsp_ready=0 for 3 cycles: rsp_valid and payload stay stable, req_ready=0.
- Mul latency: op=010, a=6, b=7 with MUL_LAT=4 -> alu_a/alu_b/alu_sel constant for 4 cycles, result=42 with rsp_valid 5 cycles after accept.
- Div by zero: op=011, a=100, b=0 -> RESP on the next cycle, result=0xFFFF_FFFF_FFFF_FFFF, ovf=1, err=1. Illegal op=111 -> result=0, zero=1, err=1.
- Reset mid-op: start div (DIV_LAT=8), pull rst_n low in cycle 3 of EXEC -> all outputs return to reset values immediately, no rsp_valid afterward, and the next add of 1+1 returns 2.
- ALU_STICKY_OVF_EN: an op with alu_ovf=1 sets sticky_ovf, which persists through a following clean add. Asserting sticky_clr on the same edge as a new overflow keeps sticky_ovf=1.
